alu: RTL and testbench



---
 rtl/alu_if.sv | 29 ++
 rtl/alu.sv | 87 ++++++++
 tb/tb_alu.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/select and result/flag bundle shared by the ALU and whatever drives it.
interface alu_if #(
  parameter int WIDTH = 4
);
  logic [2:0]       S;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] F;
  logic             cout;
  logic             zero;

  modport master (
    output S,
    output A,
    output B,
    input  F,
    input  cout,
    input  zero
  );

  modport slave (
    input  S,
    input  A,
    input  B,
    output F,
    output cout,
    output zero
  );
endinterface

// File: rtl/alu.sv
// Eight-function ALU with registered result, carry/borrow/shift-out flag and zero flag.
module alu #(
  parameter int WIDTH = 4
) (
  input logic   clk,
  input logic   rst_n,
  alu_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  op_t              op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_f;
  logic             next_cout;
  logic             next_zero;
  logic [WIDTH-1:0] f_q;
  logic             cout_q;
  logic             zero_q;

  assign op = op_t'(bus.S);

  // The extra top bit carries the add carry-out; for subtraction it goes high exactly when A < B.
  assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff = {1'b0, bus.A} - {1'b0, bus.B};

  // Select the next result and flag; every code is listed so nothing is held.
  always_comb begin
    next_f    = '0;
    next_cout = 1'b0;
    case (op)
      OP_ADD: begin
        next_f    = sum[WIDTH-1:0];
        next_cout = sum[WIDTH];
      end
      OP_SUB: begin
        next_f    = diff[WIDTH-1:0];
        next_cout = diff[WIDTH];
      end
      OP_AND: next_f = bus.A & bus.B;
      OP_OR:  next_f = bus.A | bus.B;
      OP_XOR: next_f = bus.A ^ bus.B;
      OP_NOT: next_f = ~bus.A;
      OP_SHL: begin
        next_f    = {bus.A[WIDTH-2:0], 1'b0};
        next_cout = bus.A[WIDTH-1];
      end
      OP_SHR: begin
        next_f    = {1'b0, bus.A[WIDTH-1:1]};
        next_cout = bus.A[0];
      end
      default: begin
        next_f    = '0;
        next_cout = 1'b0;
      end
    endcase
    next_zero = (next_f == '0);
  end

  // Register result and flags together; reset clears them at once, discarding any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      f_q    <= next_f;
      cout_q <= next_cout;
      zero_q <= next_zero;
    end
  end

  assign bus.F    = f_q;
  assign bus.cout = cout_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the ALU: reset, two operation sweeps, carry/borrow corners, async reset mid-stream.
module tb_alu;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive new operands on the falling edge, then sample one time unit after the next rising edge.
  task automatic apply_stimulus(input logic [2:0] s, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.S = s;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
  endtask

  // Compare all three registered outputs against hand-computed values.
  task automatic check_output(input string tag, input logic [WIDTH-1:0] exp_f,
                              input logic exp_cout, input logic exp_zero);
    total++;
    assert (bus.F === exp_f) else begin
      bad++;
      $error("[TB] FAIL %s F: got %b expected %b", tag, bus.F, exp_f);
    end
    total++;
    assert (bus.cout === exp_cout) else begin
      bad++;
      $error("[TB] FAIL %s cout: got %b expected %b", tag, bus.cout, exp_cout);
    end
    total++;
    assert (bus.zero === exp_zero) else begin
      bad++;
      $error("[TB] FAIL %s zero: got %b expected %b", tag, bus.zero, exp_zero);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.S = 3'b000;
    bus.A = 4'b0101;
    bus.B = 4'b1001;

    // Held in reset across several clock edges
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold", 4'b0000, 1'b0, 1'b1);

    // Release on a falling edge; first rising edge loads ADD result
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("release_add", 4'b1110, 1'b0, 1'b0);

    // Sweep 1: A=0101 B=1001
    apply_stimulus(3'b000, 4'b0101, 4'b1001); check_output("s1_add", 4'b1110, 1'b0, 1'b0);
    apply_stimulus(3'b001, 4'b0101, 4'b1001); check_output("s1_sub", 4'b1100, 1'b1, 1'b0);
    apply_stimulus(3'b010, 4'b0101, 4'b1001); check_output("s1_and", 4'b0001, 1'b0, 1'b0);
    apply_stimulus(3'b011, 4'b0101, 4'b1001); check_output("s1_or",  4'b1101, 1'b0, 1'b0);
    apply_stimulus(3'b100, 4'b0101, 4'b1001); check_output("s1_xor", 4'b1100, 1'b0, 1'b0);
    apply_stimulus(3'b101, 4'b0101, 4'b1001); check_output("s1_not", 4'b1010, 1'b0, 1'b0);
    apply_stimulus(3'b110, 4'b0101, 4'b1001); check_output("s1_shl", 4'b1010, 1'b0, 1'b0);
    apply_stimulus(3'b111, 4'b0101, 4'b1001); check_output("s1_shr", 4'b0010, 1'b1, 1'b0);

    // Sweep 2: A=0100 B=0010
    apply_stimulus(3'b000, 4'b0100, 4'b0010); check_output("s2_add", 4'b0110, 1'b0, 1'b0);
    apply_stimulus(3'b001, 4'b0100, 4'b0010); check_output("s2_sub", 4'b0010, 1'b0, 1'b0);
    apply_stimulus(3'b010, 4'b0100, 4'b0010); check_output("s2_and", 4'b0000, 1'b0, 1'b1);
    apply_stimulus(3'b011, 4'b0100, 4'b0010); check_output("s2_or",  4'b0110, 1'b0, 1'b0);
    apply_stimulus(3'b100, 4'b0100, 4'b0010); check_output("s2_xor", 4'b0110, 1'b0, 1'b0);
    apply_stimulus(3'b101, 4'b0100, 4'b0010); check_output("s2_not", 4'b1011, 1'b0, 1'b0);
    apply_stimulus(3'b110, 4'b0100, 4'b0010); check_output("s2_shl", 4'b1000, 1'b0, 1'b0);
    apply_stimulus(3'b111, 4'b0100, 4'b0010); check_output("s2_shr", 4'b0010, 1'b0, 1'b0);

    // Carry and wrap corners
    apply_stimulus(3'b000, 4'b1111, 4'b0001); check_output("add_wrap",    4'b0000, 1'b1, 1'b1);
    apply_stimulus(3'b001, 4'b1111, 4'b0001); check_output("sub_nowrap",  4'b1110, 1'b0, 1'b0);
    apply_stimulus(3'b001, 4'b0000, 4'b0001); check_output("sub_borrow",  4'b1111, 1'b1, 1'b0);
    apply_stimulus(3'b110, 4'b1000, 4'b0001); check_output("shl_out",     4'b0000, 1'b1, 1'b1);

    // Async reset between edges: outputs clear before any clock edge arrives
    apply_stimulus(3'b000, 4'b0101, 4'b1001); check_output("pre_reset", 4'b1110, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 4'b0000, 1'b0, 1'b1);

    // Release and resume with a SUB on the next edge
    @(negedge clk);
    rst_n = 1'b1;
    bus.S = 3'b001;
    bus.A = 4'b0101;
    bus.B = 4'b1001;
    @(posedge clk);
    #1;
    check_output("resume_sub", 4'b1100, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
